lsu_dccm_mem: RTL and testbench
===============================

Name: lsu_dccm_mem

Overview:
- Responder side of the LSU DCCM port: the banked single-port SRAM array that services the DCCM controller's dccm_rden/dccm_wren requests.
- Returns the lo and hi read words one cycle after a read, and commits store-buffer writes with their ECC bits stored verbatim; no ECC checking is done here.
- Contains a power-on init sequencer that zero-fills every entry before the array accepts traffic.

Parameters:
- DCCM_BITS, 16, byte-address width of the DCCM.
- DCCM_BANK_BITS, 3, log2 of the bank count; bank = addr[2 +: DCCM_BANK_BITS].
- DCCM_FDATA_WIDTH, 39, stored word width (32 data + 7 ECC).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- dccm_wren  in  1  write request
- dccm_rden  in  1  read request
- dccm_wr_addr  in  DCCM_BITS  write byte address
- dccm_rd_addr_lo  in  DCCM_BITS  read address, lo word
- dccm_rd_addr_hi  in  DCCM_BITS  read address, hi word (end address)
- dccm_wr_data  in  DCCM_FDATA_WIDTH  {ecc, data} write word
- dccm_rd_data_lo  out  DCCM_FDATA_WIDTH  lo read word
- dccm_rd_data_hi  out  DCCM_FDATA_WIDTH  hi read word
- dccm_init_done  out  1  array initialised, requests accepted
- dccm_bank_conflict  out  1  one-cycle pulse aligned with read data: illegal bank collision
- dccm_req_dropped  out  1  one-cycle pulse: request arrived during init

Behaviour:
- Interface: single clock; reset is synchronous and active-high.
- Address decode:
  - bank = addr[2 +: DCCM_BANK_BITS].
  - index = addr[DCCM_BITS-1 : 2+DCCM_BANK_BITS].
  - addr[1:0] is ignored.
- Depth per bank: 2^(DCCM_BITS-2-DCCM_BANK_BITS); 2048 at defaults.
- Init FSM has states INIT and READY.
  - Reset enters INIT with the index counter at 0.
  - INIT: writes all-zero words to every bank at the counter index each cycle, counter +1.
  - Leaves INIT the cycle after counter = depth-1 is written; dccm_init_done rises on entry to READY.
  - Reset asserted mid-init restarts at index 0.
  - READY holds until reset.
- During INIT, dccm_rden/dccm_wren are ignored.
  - No array write from the request.
  - dccm_req_dropped pulses the next cycle.
  - Read outputs stay 0.
- Read, READY state:
  - dccm_rden at cycle N: dccm_rd_data_lo/hi are valid at N+1 from the banks addressed by lo/hi.
  - Outputs hold their last value until the next read; no read-enable means no change.
  - If lo and hi decode to the same bank and index (aligned access), both outputs carry the same word.
  - If lo and hi decode to the same bank but different indices, the lo word goes to both outputs and dccm_bank_conflict pulses at N+1.
- Write, READY state:
  - dccm_wren at cycle N writes dccm_wr_data to the addressed bank/index at the N clock edge.
  - The write is visible to a read issued at N+1 or later.
- Simultaneous read and write, same cycle:
  - Different banks: both proceed.
  - Write bank equal to a read bank: the write wins; that read output is all-zeros at N+1 and dccm_bank_conflict pulses.
  - The other read word, if in a different bank, is unaffected.
- Reset values:
  - dccm_rd_data_lo/hi = 0.
  - dccm_init_done = 0, dccm_bank_conflict = 0, dccm_req_dropped = 0.
  - Array contents are undefined until init completes.
- Storage is inferred per bank as separate arrays, one read or write port per bank per cycle.

Test Plan:
- Init and early requests: assert rst 1 cycle, count cycles → dccm_init_done rises exactly 2048 cycles after rst deasserts. A read issued at cycle 10 → dccm_req_dropped pulses at cycle 11, dccm_rd_data_lo = 0.
- Write then read back: after init, write addr 0x0010 data 0x55_DEADBEEF, next cycle rden lo=hi=0x0010 → one cycle later lo = hi = 0x55_DEADBEEF, no conflict.
- Unaligned read across banks: write 0x0000 = A, 0x0004 = B, then rden lo=0x0002 hi=0x0005 → lo = A, hi = B.
- Read/write collision: rden lo=0x0008 hi=0x000C with wren 0x0028 (bank 2 = lo bank) → lo = 0, hi = stored word at 0x000C, dccm_bank_conflict = 1 for one cycle. A later read of 0x0028 returns the new data.
- Hold behaviour: read of 0x0010 then 5 idle cycles while writing 0x0010 → output unchanged until the next rden.
- Reset mid-init: assert rst at init cycle 1000 → dccm_init_done stays 0 until 2048 cycles after the second rst deassertion. A read of index 1500 after init returns 0.

Source files
------------

// File: rtl/lsu_dccm_mem_if.sv
// DCCM request/response bundle between the LSU DCCM controller (master)
// and the banked DCCM array (slave).
interface lsu_dccm_mem_if #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
);
  logic                        dccm_wren;
  logic                        dccm_rden;
  logic [DCCM_BITS-1:0]        dccm_wr_addr;
  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo;
  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi;
  logic                        dccm_init_done;
  logic                        dccm_bank_conflict;
  logic                        dccm_req_dropped;

  modport master (
    output dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data,
    input  dccm_rd_data_lo, dccm_rd_data_hi, dccm_init_done, dccm_bank_conflict, dccm_req_dropped
  );

  modport slave (
    input  dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data,
    output dccm_rd_data_lo, dccm_rd_data_hi, dccm_init_done, dccm_bank_conflict, dccm_req_dropped
  );
endinterface

// File: rtl/lsu_dccm_mem.sv
// Banked single-port DCCM array: zero-fill init sequencer, 1-cycle lo/hi reads,
// verbatim {ecc,data} writes, bank-collision and dropped-request reporting.
module lsu_dccm_mem #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_BANK_BITS   = 3,
  parameter int DCCM_FDATA_WIDTH = 39
) (
  input  logic           clk,
  input  logic           rst,
  lsu_dccm_mem_if.slave  dccm
);
  localparam int NBANKS = 1 << DCCM_BANK_BITS;
  localparam int IDX_W  = DCCM_BITS - 2 - DCCM_BANK_BITS;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int W      = DCCM_FDATA_WIDTH;

  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  function automatic logic [DCCM_BANK_BITS-1:0] bank_of(input logic [DCCM_BITS-1:0] a);
    return a[2 +: DCCM_BANK_BITS];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [DCCM_BITS-1:0] a);
    return a[DCCM_BITS-1 -: IDX_W];
  endfunction

  logic [0:0]       state_q;
  logic [IDX_W-1:0] init_idx_q;
  logic             ready;
  logic             rd_ok;
  logic             wr_ok;

  logic [DCCM_BANK_BITS-1:0] lo_bank, hi_bank, wr_bank;
  logic [IDX_W-1:0]          lo_idx, hi_idx, wr_idx;
  logic                      same_bank, idx_clash, wr_hit_lo, wr_hit_hi;
  logic                      unused_addr_lsbs;

  assign ready = (state_q == READY);
  assign rd_ok = ready && dccm.dccm_rden;
  assign wr_ok = ready && dccm.dccm_wren;

  assign lo_bank = bank_of(dccm.dccm_rd_addr_lo);
  assign hi_bank = bank_of(dccm.dccm_rd_addr_hi);
  assign wr_bank = bank_of(dccm.dccm_wr_addr);
  assign lo_idx  = idx_of(dccm.dccm_rd_addr_lo);
  assign hi_idx  = idx_of(dccm.dccm_rd_addr_hi);
  assign wr_idx  = idx_of(dccm.dccm_wr_addr);

  assign same_bank = (lo_bank == hi_bank);
  assign idx_clash = same_bank && (lo_idx != hi_idx);
  assign wr_hit_lo = wr_ok && (wr_bank == lo_bank);
  assign wr_hit_hi = wr_ok && (wr_bank == hi_bank);

  assign unused_addr_lsbs = ^{dccm.dccm_rd_addr_lo[1:0], dccm.dccm_rd_addr_hi[1:0],
                              dccm.dccm_wr_addr[1:0]};

  // Stage p0 -> p1: per-bank storage; a bank either writes or reads each cycle, write wins
  logic [W-1:0] bank_rd [NBANKS];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    localparam logic [DCCM_BANK_BITS-1:0] BID = DCCM_BANK_BITS'(b);
    logic [W-1:0]     mem [DEPTH];
    logic [W-1:0]     rd_q_p1;
    logic             we;
    logic             re;
    logic [IDX_W-1:0] ridx;

    assign we   = wr_ok && (wr_bank == BID);
    assign re   = rd_ok && !we && ((lo_bank == BID) || (hi_bank == BID));
    assign ridx = (lo_bank == BID) ? lo_idx : hi_idx;

    always_ff @(posedge clk) begin
      if (!ready) begin
        mem[init_idx_q] <= '0;
      end else if (we) begin
        mem[wr_idx] <= dccm.dccm_wr_data;
      end
      if (re) begin
        rd_q_p1 <= mem[ridx];
      end
    end

    assign bank_rd[b] = rd_q_p1;
  end

  // Stage p1: read steering, captured only on an accepted read so outputs hold between reads
  logic                      rd_vld_p1;
  logic                      conflict_p1;
  logic                      dropped_p1;
  logic [DCCM_BANK_BITS-1:0] lo_bank_p1, hi_bank_p1;
  logic                      lo_zero_p1, hi_zero_p1, hi_same_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      rd_vld_p1   <= 1'b0;
      conflict_p1 <= 1'b0;
      dropped_p1  <= 1'b0;
    end else begin
      if (state_q == INIT) begin
        init_idx_q <= init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(DEPTH - 1)) begin
          state_q <= READY;
        end
      end
      if (rd_ok) begin
        rd_vld_p1 <= 1'b1;
      end
      conflict_p1 <= rd_ok && (idx_clash || wr_hit_lo || wr_hit_hi);
      dropped_p1  <= !ready && (dccm.dccm_rden || dccm.dccm_wren);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_ok) begin
      lo_bank_p1 <= lo_bank;
      hi_bank_p1 <= hi_bank;
      lo_zero_p1 <= wr_hit_lo;
      hi_zero_p1 <= wr_hit_hi;
      hi_same_p1 <= same_bank;
    end
  end

  logic [W-1:0] lo_word;

  assign lo_word = (!rd_vld_p1 || lo_zero_p1) ? '0 : bank_rd[lo_bank_p1];

  assign dccm.dccm_rd_data_lo    = lo_word;
  assign dccm.dccm_rd_data_hi    = !rd_vld_p1 ? '0 :
                                   hi_same_p1 ? lo_word :
                                   hi_zero_p1 ? '0 : bank_rd[hi_bank_p1];
  assign dccm.dccm_init_done     = ready;
  assign dccm.dccm_bank_conflict = conflict_p1;
  assign dccm.dccm_req_dropped   = dropped_p1;
endmodule

// File: tb/tb_lsu_dccm_mem.sv
// Directed bench for lsu_dccm_mem: init timing, dropped requests, vector table of
// reads/writes/collisions, output hold, and reset during init.
`timescale 1ns/1ps
module tb_lsu_dccm_mem;
  localparam int AW = 16;
  localparam int DW = 39;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_dccm_mem_if #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(DW)) bus ();

  lsu_dccm_mem #(.DCCM_BITS(AW), .DCCM_BANK_BITS(3), .DCCM_FDATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .dccm (bus)
  );

  typedef struct {
    logic          rden;
    logic          wren;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] elo;
    logic [DW-1:0] ehi;
    logic          econf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  localparam logic [DW-1:0] DB = 39'h55_DEADBEEF;
  localparam logic [DW-1:0] VA = 39'h01_11111111;
  localparam logic [DW-1:0] VB = 39'h02_22222222;
  localparam logic [DW-1:0] VC = 39'h03_33333333;
  localparam logic [DW-1:0] VD = 39'h04_44444444;
  localparam logic [DW-1:0] VE = 39'h7F_CAFEF00D;
  localparam logic [DW-1:0] VF = 39'h05_55555555;
  localparam logic [DW-1:0] VG = 39'h06_66666666;
  localparam logic [DW-1:0] VH = 39'h07_77777777;
  localparam logic [DW-1:0] VN = 39'h0A_BCDEF012;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] lo,
                       input logic [AW-1:0] hi, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bus.dccm_rden       = rd;
    bus.dccm_wren       = wr;
    bus.dccm_rd_addr_lo = lo;
    bus.dccm_rd_addr_hi = hi;
    bus.dccm_wr_addr    = wa;
    bus.dccm_wr_data    = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after rst deassertion until init_done; a read at edge 10 when probe is set.
  task automatic wait_init(input string name, input bit probe);
    int k = 0;
    while (!bus.dccm_init_done && k < 3000) begin
      if (probe && k == 9) drive(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, '0);
      else drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, '0);
      step();
      k++;
      if (probe && k == 10) begin
        check("dropped_pulse", 64'(bus.dccm_req_dropped), 64'd1);
        check("dropped_rd_lo_zero", 64'(bus.dccm_rd_data_lo), 64'd0);
      end
      if (probe && k == 11) check("dropped_one_cycle", 64'(bus.dccm_req_dropped), 64'd0);
    end
    check(name, 64'(k), 64'd2048);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0010, DB, '0, '0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0010, 16'h0000, '0, DB, DB, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, VA, DB, DB, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0004, VB, DB, DB, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0002, 16'h0005, 16'h0000, '0, VA, VB, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h000C, VC, VA, VB, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0008, VD, VA, VB, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'h0008, 16'h000C, 16'h0028, VE, '0, VC, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, '0, '0, VC, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0028, 16'h0028, 16'h0000, '0, VE, VE, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'h0008, 16'h0028, 16'h0000, '0, VD, VD, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 16'h0000, 16'h0004, 16'h0030, VF, VA, VB, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 16'h0030, 16'h0030, 16'h0000, '0, VF, VF, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'hBB80, VG, VF, VF, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16'hBB80, 16'hBB80, 16'h0000, '0, VG, VG, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 16'h0000, 16'h0010, 16'h0024, VF, VA, DB, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 16'h0004, 16'h0008, 16'h0008, VH, VB, '0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 16'h0008, 16'h0008, 16'h0000, '0, VH, VH, 1'b0};

    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, '0);
    rst = 1'b1;
    step();
    check("rst_rd_lo", 64'(bus.dccm_rd_data_lo), 64'd0);
    check("rst_rd_hi", 64'(bus.dccm_rd_data_hi), 64'd0);
    check("rst_init_done", 64'(bus.dccm_init_done), 64'd0);
    check("rst_conflict", 64'(bus.dccm_bank_conflict), 64'd0);
    check("rst_dropped", 64'(bus.dccm_req_dropped), 64'd0);
    rst = 1'b0;
    wait_init("init_cycles", 1'b1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rden, vecs[i].wren, vecs[i].lo, vecs[i].hi, vecs[i].wa, vecs[i].wd);
      step();
      check($sformatf("v%0d_rd_lo", i), 64'(bus.dccm_rd_data_lo), 64'(vecs[i].elo));
      check($sformatf("v%0d_rd_hi", i), 64'(bus.dccm_rd_data_hi), 64'(vecs[i].ehi));
      check($sformatf("v%0d_conflict", i), 64'(bus.dccm_bank_conflict), 64'(vecs[i].econf));
      check($sformatf("v%0d_dropped", i), 64'(bus.dccm_req_dropped), 64'd0);
    end

    // Output hold: read once, then overwrite the same word while idle on the read side.
    drive(1'b1, 1'b0, 16'h0010, 16'h0010, 16'h0000, '0);
    step();
    check("hold_first_read", 64'(bus.dccm_rd_data_lo), 64'(DB));
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0010, VN);
      step();
      check($sformatf("hold_lo_%0d", j), 64'(bus.dccm_rd_data_lo), 64'(DB));
      check($sformatf("hold_hi_%0d", j), 64'(bus.dccm_rd_data_hi), 64'(DB));
    end
    drive(1'b1, 1'b0, 16'h0010, 16'h0010, 16'h0000, '0);
    step();
    check("hold_reread", 64'(bus.dccm_rd_data_lo), 64'(VN));

    // Reset during init restarts the zero-fill from index 0.
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, '0);
    rst = 1'b1;
    step();
    check("rst2_rd_lo", 64'(bus.dccm_rd_data_lo), 64'd0);
    rst = 1'b0;
    repeat (1000) step();
    check("midinit_not_done", 64'(bus.dccm_init_done), 64'd0);
    rst = 1'b1;
    step();
    check("rst3_init_done", 64'(bus.dccm_init_done), 64'd0);
    rst = 1'b0;
    wait_init("reinit_cycles", 1'b0);
    drive(1'b1, 1'b0, 16'hBB80, 16'hBB80, 16'h0000, '0);
    step();
    check("idx1500_zero_lo", 64'(bus.dccm_rd_data_lo), 64'd0);
    check("idx1500_zero_hi", 64'(bus.dccm_rd_data_hi), 64'd0);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
